cla_pipe_adder16: RTL and testbench
===================================

// Module: cla_pipe_adder16
// PURPOSE
//   Pipelined multi-nibble carry-lookahead adder built from 4-bit lookahead slices.
//   A second-level lookahead unit consumes each slice's group propagate (PG) and group generate (GG).
//   It registers operands, computes per-slice PG/GG, resolves the inter-slice carries, and registers the sum.
//   Valid/ready handshakes on both sides let it sit between an operand source and a result consumer in the datapath.
// PARAMETERS
//   WIDTH     16   operand/sum width; must be a multiple of 4 (NSLICE = WIDTH/4 slices)
// PORTS
//   clk        in   1      single clock; all state updates on rising edge
//   rst        in   1      synchronous, active-high reset
//   in_valid   in   1      A/B/c_in are valid this cycle
//   in_ready   out  1      block accepts operands this cycle
//   A          in   WIDTH  operand A (unsigned; signed view for ovf)
//   B          in   WIDTH  operand B
//   c_in       in   1      carry into bit 0
//   out_valid  out  1      S/c_out/PG/GG/ovf hold a valid result
//   out_ready  in   1      consumer takes result this cycle
//   S          out  WIDTH  sum A+B+c_in, low WIDTH bits
//   c_out      out  1      carry out of bit WIDTH-1
//   PG         out  1      block propagate: AND of all slice PGs
//   GG         out  1      block generate: carry-out assuming c_in=0
//   ovf        out  1      signed overflow: carry into MSB XOR c_out
// BEHAVIOUR
//   - Bit-level definitions: p[i]=A[i]^B[i], g[i]=A[i]&B[i].
//   - Slice definitions: PGk = &p of the 4 bits. GGk = g3|p3g2|p3p2g1|p3p2p1g0.
//   - Stage 1 (S1) registers A, B, c_in, p, g, and the per-slice PGk/GGk. It also has an s1_valid flag.
//   - Stage 2 (S2) is the second-level lookahead: c0=c_in, c(k+1)=GGk|(PGk&ck).
//     - Intra-slice carries use the standard 4-bit lookahead equations from each slice's own carry ck.
//     - S2 registers S, c_out=c(NSLICE), PG, GG, ovf, and out_valid.
//   - Handshakes:
//     - Input transfer when in_valid&in_ready. Output transfer when out_valid&out_ready.
//     - s2_adv = !out_valid | out_ready.
//     - in_ready = !s1_valid | s2_adv. This is combinational from out_ready; there are no bubbles.
//     - When s1_valid&s2_adv, S1 moves to S2. When no input transfer happens the same cycle, s1_valid clears.
//   - Latency is 2 cycles: operands accepted at edge N appear on the outputs after edge N+1.
//     Throughput is 1 result/clk while out_ready=1.
//   - Stall: with out_ready=0 and out_valid=1, S2 holds.
//     - A second item is held in S1 and in_ready drops to 0.
//     - No item is ever dropped, duplicated or reordered.
//   - Output stability: while out_valid=1 and out_ready=0, S/c_out/PG/GG/ovf do not change.
//   - Simultaneous events: a full pipe with out_ready=1 and in_valid=1 accepts new operands and shifts S1 to S2 in the same cycle.
//   - Width and arithmetic:
//     - The sum wraps modulo 2^WIDTH.
//     - c_out equals bit WIDTH of the (WIDTH+1)-bit A+B+c_in.
//     - GG ignores c_in.
//   - Reset (rst=1 at a clock edge, at any time including mid-stall):
//     - s1_valid=0 and out_valid=0. S, c_out, PG, GG and ovf are 0.
//     - In-flight items are discarded.
//     - in_ready=1 from the first cycle after reset deasserts.
//   - Outputs are registered. No output other than in_ready depends combinationally on inputs.
// TESTING (WIDTH=16)
//   1. After reset, send A=0x0001, B=0x0000, c_in=0 with out_ready=1.
//      -> 2 cycles later: out_valid=1, S=0x0001, c_out=0, PG=0, GG=0, ovf=0.
//   2. Send A=0xFFFF, B=0x0000, c_in=1 (full ripple through all slices).
//      -> S=0x0000, c_out=1, PG=1, GG=0, ovf=0.
//   3. Send A=0x7FFF, B=0x0001, c_in=0 -> S=0x8000, c_out=0, ovf=1.
//      Then send A=0xFFFF, B=0xFFFF, c_in=1 -> S=0xFFFF, c_out=1, PG=0, GG=1, ovf=0.
//   4. Stream 4 items back-to-back with out_ready=0 for 3 cycles, then 1.
//      -> in_ready=0 once 2 items are held. Outputs stay stable while stalled.
//      -> All 4 results emerge in order with correct sums.
//      -> Throughput is 1/clk after out_ready rises.
//   5. With 2 items in flight and out_ready=0, assert rst for 1 cycle.
//      -> out_valid=0, all outputs 0, in_ready=1 next cycle.
//      -> A new item A=0x1234, B=0x4321 gives S=0x5555 after 2 cycles.
//   6. Randomised scoreboard, 10k items, random in_valid/out_ready.
//      -> Every result matches the (WIDTH+1)-bit reference sum, plus PG/GG/ovf recomputed in the bench.

Source files
------------

// File: rtl/cla_pipe_adder16.sv
// -----------------------------------------------------------------------------
// cla_pipe_adder16
//   Two-stage pipelined carry-lookahead adder. The operands are split into
//   4-bit slices. Each slice produces a group propagate (PG) and a group
//   generate (GG). A second-level lookahead unit resolves the carries between
//   slices from those PG/GG pairs. Inside each slice, the standard 4-bit
//   lookahead equations then run from the slice's own carry-in.
//
//   Stage 1 registers the operands, the bit-level propagate/generate terms and
//   the per-slice PG/GG. Stage 2 resolves the carries and registers the sum
//   and the status flags. Valid/ready handshakes are provided on both sides.
//   The pipe accepts a new item on every clock while the consumer is ready.
//
// Ports
//   clk        clock, rising edge
//   rst        synchronous active-high reset; clears valids and all outputs
//   in_valid   A/B/c_in carry a valid operand set this cycle
//   in_ready   block can accept operands (combinational from out_ready)
//   A, B       operands (unsigned; signed view used for ovf)
//   c_in       carry into bit 0
//   out_valid  S/c_out/PG/GG/ovf hold a valid result
//   out_ready  consumer takes the result this cycle
//   S          A+B+c_in, low WIDTH bits
//   c_out      carry out of bit WIDTH-1
//   PG         block propagate (AND of all slice PGs)
//   GG         block generate (carry-out with c_in forced to 0)
//   ovf        signed overflow (carry into MSB xor carry out of MSB)
//
// WIDTH must be a multiple of 4.
// -----------------------------------------------------------------------------
module cla_pipe_adder16 #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             c_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] S,
  output logic             c_out,
  output logic             PG,
  output logic             GG,
  output logic             ovf
);

  localparam int NSLICE = WIDTH / 4;

  // Group generate of one 4-bit slice.
  function automatic logic slice_gg(input logic [3:0] p4, input logic [3:0] g4);
    return g4[3]
         | (p4[3] & g4[2])
         | (p4[3] & p4[2] & g4[1])
         | (p4[3] & p4[2] & p4[1] & g4[0]);
  endfunction

  // Carries into bits 0..3 of one slice, from the slice carry-in ck.
  // Each carry is a flat two-level expression, not a ripple.
  function automatic logic [3:0] slice_carries(input logic [3:0] p4,
                                               input logic [3:0] g4,
                                               input logic       ck);
    logic [3:0] c;
    c[0] = ck;
    c[1] = g4[0] | (p4[0] & ck);
    c[2] = g4[1] | (p4[1] & g4[0]) | (p4[1] & p4[0] & ck);
    c[3] = g4[2] | (p4[2] & g4[1]) | (p4[2] & p4[1] & g4[0])
         | (p4[2] & p4[1] & p4[0] & ck);
    return c;
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic              s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0]  s1_a_q,     s1_a_d;
  logic [WIDTH-1:0]  s1_b_q,     s1_b_d;
  logic              s1_cin_q,   s1_cin_d;
  logic [WIDTH-1:0]  s1_p_q,     s1_p_d;
  logic [WIDTH-1:0]  s1_g_q,     s1_g_d;
  logic [NSLICE-1:0] s1_pg_q,    s1_pg_d;
  logic [NSLICE-1:0] s1_gg_q,    s1_gg_d;

  logic              out_valid_q, out_valid_d;
  logic [WIDTH-1:0]  s_q,         s_d;
  logic              c_out_q,     c_out_d;
  logic              pg_q,        pg_d;
  logic              gg_q,        gg_d;
  logic              ovf_q,       ovf_d;

  // ---------------------------------------------------------------------------
  // Handshake
  // ---------------------------------------------------------------------------
  logic s2_adv;
  logic in_xfer;

  // Stage 2 can take a new item when it is empty or is being drained this cycle.
  assign s2_adv   = !out_valid_q | out_ready;
  // Stage 1 can take a new item when it is empty or is moving into stage 2.
  assign in_ready = !s1_valid_q | s2_adv;
  assign in_xfer  = in_valid & in_ready;

  // ---------------------------------------------------------------------------
  // Stage 1: operand capture, bit and slice propagate/generate
  // ---------------------------------------------------------------------------
  always_comb begin
    logic [WIDTH-1:0] p_bits;
    logic [WIDTH-1:0] g_bits;

    p_bits     = A ^ B;
    g_bits     = A & B;

    s1_valid_d = s1_valid_q;
    s1_a_d     = s1_a_q;
    s1_b_d     = s1_b_q;
    s1_cin_d   = s1_cin_q;
    s1_p_d     = s1_p_q;
    s1_g_d     = s1_g_q;
    s1_pg_d    = s1_pg_q;
    s1_gg_d    = s1_gg_q;

    if (in_xfer) begin
      s1_valid_d = 1'b1;
      s1_a_d     = A;
      s1_b_d     = B;
      s1_cin_d   = c_in;
      s1_p_d     = p_bits;
      s1_g_d     = g_bits;
      for (int k = 0; k < NSLICE; k++) begin
        s1_pg_d[k] = &p_bits[4*k +: 4];
        s1_gg_d[k] = slice_gg(p_bits[4*k +: 4], g_bits[4*k +: 4]);
      end
    end else if (s2_adv) begin
      // Any held item has moved on to stage 2, and nothing replaced it.
      s1_valid_d = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: second-level lookahead, sum and flags
  // ---------------------------------------------------------------------------
  always_comb begin
    logic [NSLICE:0]  ck;      // slice carries from the real c_in
    logic [NSLICE:0]  ck_gen;  // slice carries with c_in forced to 0 (for GG)
    logic [WIDTH-1:0] bit_c;   // carry into every bit position

    ck        = '0;
    ck_gen    = '0;
    bit_c     = '0;
    ck[0]     = s1_cin_q;
    ck_gen[0] = 1'b0;
    for (int k = 0; k < NSLICE; k++) begin
      ck[k+1]     = s1_gg_q[k] | (s1_pg_q[k] & ck[k]);
      ck_gen[k+1] = s1_gg_q[k] | (s1_pg_q[k] & ck_gen[k]);
      bit_c[4*k +: 4] = slice_carries(s1_p_q[4*k +: 4], s1_g_q[4*k +: 4], ck[k]);
    end

    out_valid_d = out_valid_q;
    s_d         = s_q;
    c_out_d     = c_out_q;
    pg_d        = pg_q;
    gg_d        = gg_q;
    ovf_d       = ovf_q;

    if (s2_adv) begin
      out_valid_d = s1_valid_q;
      // Result registers load only with a real item. This keeps the last
      // result visible but flagged invalid when the pipe drains.
      if (s1_valid_q) begin
        s_d     = s1_a_q ^ s1_b_q ^ bit_c;
        c_out_d = ck[NSLICE];
        pg_d    = &s1_pg_q;
        gg_d    = ck_gen[NSLICE];
        ovf_d   = bit_c[WIDTH-1] ^ ck[NSLICE];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_a_q      <= '0;
      s1_b_q      <= '0;
      s1_cin_q    <= 1'b0;
      s1_p_q      <= '0;
      s1_g_q      <= '0;
      s1_pg_q     <= '0;
      s1_gg_q     <= '0;
      out_valid_q <= 1'b0;
      s_q         <= '0;
      c_out_q     <= 1'b0;
      pg_q        <= 1'b0;
      gg_q        <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_a_q      <= s1_a_d;
      s1_b_q      <= s1_b_d;
      s1_cin_q    <= s1_cin_d;
      s1_p_q      <= s1_p_d;
      s1_g_q      <= s1_g_d;
      s1_pg_q     <= s1_pg_d;
      s1_gg_q     <= s1_gg_d;
      out_valid_q <= out_valid_d;
      s_q         <= s_d;
      c_out_q     <= c_out_d;
      pg_q        <= pg_d;
      gg_q        <= gg_d;
      ovf_q       <= ovf_d;
    end
  end

  assign out_valid = out_valid_q;
  assign S         = s_q;
  assign c_out     = c_out_q;
  assign PG        = pg_q;
  assign GG        = gg_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_cla_pipe_adder16.sv
// -----------------------------------------------------------------------------
// tb_cla_pipe_adder16
//   Directed vectors with literal expectations, plus a reference model. The
//   model is an arithmetic sum with a queue of accepted items. It checks
//   out_valid timing, in_ready, and every valid result on every cycle.
// -----------------------------------------------------------------------------
module tb_cla_pipe_adder16;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] A;
  logic [15:0] B;
  logic        c_in;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] S;
  logic        c_out;
  logic        PG;
  logic        GG;
  logic        ovf;

  always #5 clk = ~clk;

  cla_pipe_adder16 #(.WIDTH(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .c_in      (c_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .S         (S),
    .c_out     (c_out),
    .PG        (PG),
    .GG        (GG),
    .ovf       (ovf)
  );

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        ci;
    int          acc_edge;   // index of the clock edge that accepted it
  } item_t;

  item_t sb[$];
  int    n_vec = 0;
  int    n_err = 0;
  int    n_out = 0;
  int    e     = 0;          // rising edges seen by the compare process
  bit    armed = 1'b0;
  bit    just_reset = 1'b0;

  // Result packed as {c_out, S, PG, GG, ovf}.
  function automatic logic [19:0] model(input logic [15:0] a, input logic [15:0] b,
                                        input logic ci);
    logic [16:0] full;
    logic [16:0] nocin;
    logic [15:0] s;
    logic        ov;
    logic        all_p;
    full  = {1'b0, a} + {1'b0, b} + {16'b0, ci};
    nocin = {1'b0, a} + {1'b0, b};
    s     = full[15:0];
    ov    = (a[15] == b[15]) && (s[15] != a[15]);
    all_p = ((a ^ b) == 16'hFFFF);
    return {full[16], s, all_p, nocin[16], ov};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Compare process. It samples 2 time units after each falling edge, when
  // the driver inputs have settled. It then records the transfers that the
  // next rising edge will perform.
  initial begin : compare
    bit rst_s;
    forever begin
      @(negedge clk);
      #2;
      rst_s = rst;
      if (armed) begin
        if (just_reset) begin
          check("rst_out_valid", {31'b0, out_valid}, 32'd0);
          check("rst_outputs", {12'b0, c_out, S, PG, GG, ovf}, 32'd0);
          check("rst_in_ready", {31'b0, in_ready}, 32'd1);
          just_reset = 1'b0;
        end
        check("out_valid", {31'b0, out_valid},
              {31'b0, (sb.size() > 0 && e >= sb[0].acc_edge + 1)});
        check("in_ready", {31'b0, in_ready},
              {31'b0, !(sb.size() == 2 && !out_ready)});
        if (out_valid && sb.size() > 0)
          check("result", {12'b0, c_out, S, PG, GG, ovf},
                {12'b0, model(sb[0].a, sb[0].b, sb[0].ci)});
        if (!rst_s) begin
          if (out_valid && out_ready && sb.size() > 0) begin
            void'(sb.pop_front());
            n_out++;
          end
          if (in_valid && in_ready) begin
            sb.push_back('{A, B, c_in, e + 1});
            n_vec++;
          end
        end
      end
      @(posedge clk);
      e++;
      if (rst_s) begin
        sb.delete();
        armed      = 1'b1;
        just_reset = 1'b1;
      end
    end
  end

  // One item into an empty pipe with out_ready=1. The result is checked
  // against literals 2 cycles after acceptance.
  task automatic send_one(input logic [15:0] a, input logic [15:0] b, input logic ci,
                          input logic [15:0] es, input logic ec, input logic epg,
                          input logic egg, input logic eovf);
    @(negedge clk);
    A = a; B = b; c_in = ci; in_valid = 1'b1; out_ready = 1'b1;
    #1;
    check("lit_in_ready", {31'b0, in_ready}, 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    #3;
    check("lit_out_valid", {31'b0, out_valid}, 32'd1);
    check("lit_S", {16'b0, S}, {16'b0, es});
    check("lit_flags", {28'b0, c_out, PG, GG, ovf}, {28'b0, ec, epg, egg, eovf});
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin : driver
    logic [15:0] sa [4];
    logic [15:0] sbv[4];
    logic        sc [4];
    int          idx;
    int          cyc;
    int          sent;
    bit          have;
    int          mode;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    A = '0; B = '0; c_in = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Basic directed vectors
    send_one(16'h0001, 16'h0000, 1'b0, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b0);
    send_one(16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0);
    send_one(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b0, 1'b0, 1'b1);
    send_one(16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b1, 1'b0);

    // Stall: 4 items back-to-back, out_ready low for 3 cycles
    sa[0] = 16'h1111; sbv[0] = 16'h2222; sc[0] = 1'b0;
    sa[1] = 16'h8000; sbv[1] = 16'h8000; sc[1] = 1'b0;
    sa[2] = 16'h0F0F; sbv[2] = 16'hF0F1; sc[2] = 1'b0;
    sa[3] = 16'hABCD; sbv[3] = 16'h1234; sc[3] = 1'b1;
    idx = 0;
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      out_ready = (c >= 3);
      if (idx < 4) begin
        A = sa[idx]; B = sbv[idx]; c_in = sc[idx]; in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (c == 2) check("stall_in_ready", {31'b0, in_ready}, 32'd0);
      if (c >= 3) check("stream_out_valid", {31'b0, out_valid}, 32'd1);
      if (c == 2) check("stall_S_item0", {16'b0, S}, 32'h3333);
      if (c == 3) check("stall_S_item0_hold", {16'b0, S}, 32'h3333);
      if (c == 4) check("stream_item1", {15'b0, c_out, S}, 32'h10000);
      if (c == 6) check("stream_item3", {15'b0, c_out, S}, 32'h0BE02);
      if (in_valid && in_ready) idx++;
    end
    check("stall_all_accepted", idx, 4);
    @(negedge clk);
    in_valid = 1'b0;

    // Reset with two items in flight and the consumer stalled
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b1; A = 16'h0101; B = 16'h0202; c_in = 1'b0;
    @(negedge clk);
    A = 16'h0303; B = 16'h0404;
    @(negedge clk);
    in_valid = 1'b0; rst = 1'b1;
    #1;
    check("pre_rst_in_ready", {31'b0, in_ready}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #3;
    check("post_rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("post_rst_S", {16'b0, S}, 32'd0);
    check("post_rst_in_ready", {31'b0, in_ready}, 32'd1);
    send_one(16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0, 1'b0, 1'b0);

    // Random traffic
    sent = 0; cyc = 0; have = 1'b0;
    while (sent < 10000 && cyc < 60000) begin
      @(negedge clk);
      out_ready = ($urandom_range(3, 0) != 0);
      if (!have) begin
        mode = $urandom_range(7, 0);
        A    = 16'($urandom);
        B    = 16'($urandom);
        c_in = 1'($urandom);
        if (mode == 0) A = 16'hFFFF;
        if (mode == 1) B = ~A;
        if (mode == 2) begin A = 16'h8000; B = 16'($urandom_range(1, 0) ? 16'h8000 : 16'h7FFF); end
        have = 1'b1;
      end
      in_valid = ($urandom_range(3, 0) != 0);
      #1;
      if (in_valid && in_ready) begin
        sent++;
        have = 1'b0;
      end
      cyc++;
    end
    check("random_all_sent", sent, 10000);

    // Drain
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    cyc = 0;
    while (sb.size() > 0 && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    @(negedge clk);
    #3;
    check("drain_empty", sb.size(), 0);
    check("drain_out_valid", {31'b0, out_valid}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
